mmio_bus_bridge: RTL and testbench
==================================

MMIO_BUS_BRIDGE -- requirements
Module: mmio_bus_bridge

Interface
REQ-001 SHALL have parameter NSLV, default 4: number of slave ports (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles to wait for slave ready (1..255).
REQ-003 SHALL have parameter SLV_BASE, default {0x0000_0000, 0xFFFF_F000, 0xFFFF_F060, 0xFFFF_F070}: NSLV x 32-bit packed base addresses, slave 0 in the LSBs.
REQ-004 SHALL have parameter SLV_MASK, default {0xFFFF_0000, 0xFFFF_FFF0, 0xFFFF_FFF0, 0xFFFF_FFF0}: NSLV x 32-bit packed compare masks.
REQ-005 cpu_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 cpu_rst  in  1  asynchronous, active-low reset.
REQ-007 req  in  1  one-cycle request strobe from the CPU side.
REQ-008 we  in  1  1 = write, 0 = read.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  write data.
REQ-011 wstrb  in  4  byte enables; ignored on reads.
REQ-012 busy  out  1  high whenever a transaction is in flight.
REQ-013 ack  out  1  one-cycle completion pulse.
REQ-014 err  out  1  qualifies ack: unmapped address or timeout.
REQ-015 rdata  out  32  read data, valid with ack.
REQ-016 s_sel  out  NSLV  one-hot slave select.
REQ-017 s_we, s_addr[31:0], s_wdata[31:0], s_wstrb[3:0]  out  registered copies of the request.
REQ-018 s_rdata  in  NSLV*32  packed slave read data, slave 0 in the LSBs.
REQ-019 s_rdy  in  NSLV  per-slave ready/completion.

Function
REQ-020 SHALL implement the FSM states IDLE, DECODE, WAIT and RESP.
REQ-021 In IDLE with req=1, SHALL register we/addr/wdata/wstrb and go to DECODE.
REQ-022 SHALL ignore req in any state other than IDLE, with no queuing.
REQ-023 In DECODE, SHALL match slave i when (addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]).
REQ-024 If several slaves match, SHALL select the lowest index.
REQ-025 On a match in DECODE, SHALL assert s_sel[i] from the next cycle, clear the timeout counter and go to WAIT.
REQ-026 On no match in DECODE, SHALL go to RESP with err=1 and rdata=0xDEAD_BEEF, and SHALL assert no s_sel bit.
REQ-027 In WAIT, SHALL hold s_sel and the s_* request outputs stable.
REQ-028 In WAIT with s_rdy[i]=1 for the selected slave, SHALL capture s_rdata[i] (reads only; writes capture 0), drop s_sel next cycle and go to RESP with err=0.
REQ-029 SHALL ignore s_rdy of unselected slaves.
REQ-030 SHALL increment the 8-bit timeout counter once per WAIT cycle without s_rdy.
REQ-031 If the counter reaches TIMEOUT with s_rdy still low, SHALL drop s_sel and go to RESP with err=1 and rdata=0xDEAD_BEEF.
REQ-032 s_rdy arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion.
REQ-033 In RESP, SHALL assert ack=1 for exactly one cycle with err and rdata valid, then return to IDLE.
REQ-034 ack/err SHALL be 0 outside RESP.
REQ-035 rdata SHALL hold its last value outside RESP.
REQ-036 busy SHALL be 1 in DECODE, WAIT and RESP, and 0 in IDLE.
REQ-037 A slave with s_rdy tied high SHALL give minimum latency: req at cycle 0 -> s_sel at cycle 2 -> ack at cycle 3.
REQ-038 A new req SHALL be accepted in the cycle after ack (back-to-back).
REQ-039 SHALL keep the per-transaction timeout independent of earlier transactions.

Reset
REQ-040 Asserting cpu_rst low at any time, including mid-WAIT, SHALL immediately force state=IDLE, s_sel=0, ack=0, err=0, busy=0, rdata=0, s_we=0, s_addr=0, s_wdata=0, s_wstrb=0 and counter=0.
REQ-041 An in-flight transaction SHALL be discarded by reset with no ack.
REQ-042 After cpu_rst deasserts, the first req SHALL be accepted no earlier than the next rising edge.

Structure
REQ-043 The state encoding, error pattern 0xDEAD_BEEF and default base/mask values SHALL live in the shared defines header alongside the existing peripheral address constants.
REQ-044 The address decoder (addr, SLV_BASE, SLV_MASK -> hit and index) SHALL be one combinational sub-module, mmio_addr_decode.
REQ-045 The FSM, timeout counter and registers SHALL stay in mmio_bus_bridge.

Verification
REQ-046 Read 0x0000_0010, slave 0 s_rdy tied high, s_rdata0=0x1234_5678 -> s_sel=0001 at cycle 2, ack at cycle 3, rdata=0x1234_5678, err=0.
REQ-047 Write 0xFFFF_F064, wdata=0xA5, wstrb=0001, slave 2 raising s_rdy 3 cycles after s_sel -> s_sel=0100 held 4 cycles, s_wdata=0xA5, ack with err=0.
REQ-048 Read 0x8000_0000 (unmapped) -> no s_sel ever, ack at cycle 2 with err=1 and rdata=0xDEAD_BEEF.
REQ-049 Read 0xFFFF_F000, slave 1 never ready, TIMEOUT=15 -> s_sel high for exactly 15 cycles, then ack with err=1 and rdata=0xDEAD_BEEF.
REQ-050 Pulse req during WAIT, then a back-to-back req in the cycle after ack -> mid-WAIT req ignored, second req completes normally.
REQ-051 Assert cpu_rst low in the 2nd WAIT cycle -> s_sel and busy drop immediately, no ack, and a following read completes normally.

Source files
------------

// File: rtl/mmio_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge_pkg
// Shared definitions for the MMIO bus bridge: peripheral address map,
// default slave base/mask tables, bridge FSM state encoding and the error
// read-data pattern returned on unmapped or timed-out accesses.
// ---------------------------------------------------------------------------
package mmio_bus_bridge_pkg;

  // Peripheral address map
  localparam logic [31:0] PERIPH_RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] PERIPH_RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH_UART_BASE  = 32'hFFFF_F000;
  localparam logic [31:0] PERIPH_UART_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] PERIPH_TIMER_BASE = 32'hFFFF_F060;
  localparam logic [31:0] PERIPH_TIMER_MASK = 32'hFFFF_FFF0;
  localparam logic [31:0] PERIPH_GPIO_BASE  = 32'hFFFF_F070;
  localparam logic [31:0] PERIPH_GPIO_MASK  = 32'hFFFF_FFF0;

  // Default 4-slave decode tables, slave 0 in the least significant word
  localparam logic [4*32-1:0] DEF_SLV_BASE = {PERIPH_GPIO_BASE, PERIPH_TIMER_BASE,
                                              PERIPH_UART_BASE, PERIPH_RAM_BASE};
  localparam logic [4*32-1:0] DEF_SLV_MASK = {PERIPH_GPIO_MASK, PERIPH_TIMER_MASK,
                                              PERIPH_UART_MASK, PERIPH_RAM_MASK};

  // Read data returned together with err
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  // Masked address compare against one slave window
  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// ---------------------------------------------------------------------------
// mmio_addr_decode
// Purely combinational address decoder. Compares the address against every
// slave window and reports whether any matched and the lowest matching index.
// Ports:
//   addr_i  [31:0]      address to decode
//   hit_o               at least one slave window matched
//   idx_o   [IDX_W-1:0] lowest-index matching slave (0 when no hit)
// ---------------------------------------------------------------------------
module mmio_addr_decode
  import mmio_bus_bridge_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter int                 IDX_W    = (NSLV > 1) ? $clog2(NSLV) : 1,
  parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest matching index is the one that sticks
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (addr_match(addr_i, SLV_BASE[i*32 +: 32], SLV_MASK[i*32 +: 32])) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge
// Single-outstanding CPU-to-MMIO bridge. A one-cycle request is registered,
// decoded to one slave, held on the slave side until that slave signals ready
// or a timeout expires, then completed with a one-cycle ack (err on unmapped
// address or timeout).
// Ports:
//   cpu_clk, cpu_rst            clock, asynchronous active-low reset
//   req, we, addr, wdata, wstrb CPU request (req is a one-cycle strobe)
//   busy, ack, err, rdata       CPU status / response
//   s_sel, s_we, s_addr,
//   s_wdata, s_wstrb            registered slave-side request, one-hot select
//   s_rdata, s_rdy              packed slave read data and ready, slave 0 LSBs
// ---------------------------------------------------------------------------
module mmio_bus_bridge
  import mmio_bus_bridge_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter int                 TIMEOUT  = 15,
  parameter logic [NSLV*32-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NSLV*32-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic                 busy,
  output logic                 ack,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic [NSLV-1:0]      s_sel,
  output logic                 s_we,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [NSLV*32-1:0]   s_rdata,
  input  logic [NSLV-1:0]      s_rdy
);

  localparam int          IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [7:0]  TMO   = 8'(TIMEOUT);

  bridge_state_e    state_q, state_d;
  logic             s_we_q, s_we_d;
  logic [31:0]      s_addr_q, s_addr_d;
  logic [31:0]      s_wdata_q, s_wdata_d;
  logic [3:0]       s_wstrb_q, s_wstrb_d;
  logic [NSLV-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic [7:0]       cnt_inc;
  logic [31:0]      slv_rdata [NSLV];

  mmio_addr_decode #(
    .NSLV     (NSLV),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (s_addr_q),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      slv_rdata[i] = s_rdata[i*32 +: 32];
    end
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          s_we_d    = we;
          s_addr_d  = addr;
          s_wdata_d = wdata;
          s_wstrb_d = wstrb;
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec_hit) begin
          sel_d          = '0;
          sel_d[dec_idx] = 1'b1;
          idx_d          = dec_idx;
          cnt_d          = 8'd0;
          state_d        = ST_WAIT;
        end else begin
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
          state_d = ST_RESP;
        end
      end

      ST_WAIT: begin
        // Ready is checked before the timeout so a same-cycle ready wins
        if (s_rdy[idx_q]) begin
          sel_d   = '0;
          err_d   = 1'b0;
          rdata_d = s_we_q ? 32'd0 : slv_rdata[idx_q];
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            sel_d   = '0;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q   <= ST_IDLE;
      s_we_q    <= 1'b0;
      s_addr_q  <= 32'd0;
      s_wdata_q <= 32'd0;
      s_wstrb_q <= 4'd0;
      sel_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign ack     = (state_q == ST_RESP);
  assign err     = ack & err_q;
  assign rdata   = rdata_q;
  assign s_sel   = sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mmio_bus_bridge
// Self-checking bench for mmio_bus_bridge: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mmio_bus_bridge;

  localparam int NSLV = 4;
  localparam int TMO  = 15;

  localparam logic [NSLV*32-1:0] BASE = {32'hFFFF_F070, 32'hFFFF_F060,
                                         32'hFFFF_F000, 32'h0000_0000};
  localparam logic [NSLV*32-1:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                         32'hFFFF_FFF0, 32'hFFFF_0000};

  logic [31:0] m_base [NSLV] = '{32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_F060, 32'hFFFF_F070};
  logic [31:0] m_mask [NSLV] = '{32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

  logic                cpu_clk;
  logic                cpu_rst;
  logic                req;
  logic                we;
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                busy;
  logic                ack;
  logic                err;
  logic [31:0]         rdata;
  logic [NSLV-1:0]     s_sel;
  logic                s_we;
  logic [31:0]         s_addr;
  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic [NSLV*32-1:0]  s_rdata;
  logic [NSLV-1:0]     s_rdy;

  int n_vec = 0;
  int n_bad = 0;

  mmio_bus_bridge #(
    .NSLV     (NSLV),
    .TIMEOUT  (TMO),
    .SLV_BASE (BASE),
    .SLV_MASK (MASK)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .busy    (busy),
    .ack     (ack),
    .err     (err),
    .rdata   (rdata),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_rdy   (s_rdy)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Lowest-index window that contains the address, -1 if unmapped
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++) begin
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    end
    return -1;
  endfunction

  task automatic randomize_rdata();
    for (int i = 0; i < NSLV; i++) s_rdata[i*32 +: 32] = $urandom;
  endtask

  // Issue one transaction starting at a negedge; the selected slave raises
  // ready dly cycles after select. Returns at the negedge after ack, so a
  // following call issues its request back-to-back.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int dly, input bit poke);
    int              m;
    int              sel_cyc;
    int              ack_cyc;
    int              exp_ack;
    int              exp_sel;
    logic [31:0]     exp_rd;
    logic            exp_err;
    logic [31:0]     got_rd;
    logic            got_err;
    logic [NSLV-1:0] exp_oh;
    bit              s_ok;

    m      = ref_slave(a);
    exp_oh = '0;
    if (m < 0) begin
      exp_ack = 2; exp_sel = 0; exp_err = 1'b1; exp_rd = 32'hDEAD_BEEF;
    end else begin
      exp_oh[m] = 1'b1;
      if (dly < TMO) begin
        exp_sel = dly + 1; exp_ack = dly + 3; exp_err = 1'b0;
        exp_rd  = w ? 32'd0 : s_rdata[m*32 +: 32];
      end else begin
        exp_sel = TMO; exp_ack = TMO + 2; exp_err = 1'b1; exp_rd = 32'hDEAD_BEEF;
      end
    end

    req = 1'b1; we = w; addr = a; wdata = wd; wstrb = ws;
    @(negedge cpu_clk);
    // Scramble the request inputs: only the registered copies may be used
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    chk("busy_decode", 32'(busy), 32'd1);

    sel_cyc = 0; ack_cyc = 0; s_ok = 1'b1; got_rd = '0; got_err = 1'b0;
    for (int c = 1; c <= TMO + 8; c++) begin
      if (s_sel != '0) begin
        sel_cyc++;
        if (s_sel !== exp_oh || s_we !== w || s_addr !== a || s_wdata !== wd ||
            s_wstrb !== ws || busy !== 1'b1 || ack !== 1'b0) s_ok = 1'b0;
      end
      if (ack === 1'b1) begin
        ack_cyc = c; got_rd = rdata; got_err = err;
        break;
      end
      req   = poke && (s_sel != '0) && (sel_cyc == 1);
      s_rdy = (((s_sel != '0) && (sel_cyc > dly)) ? s_sel : '0) | (NSLV'($urandom) & ~s_sel);
      @(negedge cpu_clk);
    end
    if (ack_cyc == 0) chk("ack_seen", 32'd0, 32'd1);

    chk("ack_cycle",  32'(ack_cyc), 32'(exp_ack));
    chk("err",        32'(got_err), 32'(exp_err));
    chk("rdata",      got_rd,       exp_rd);
    chk("sel_cycles", 32'(sel_cyc), 32'(exp_sel));
    chk("sel_stable", 32'(s_ok),    32'd1);

    req   = 1'b0;
    s_rdy = NSLV'($urandom);
    @(negedge cpu_clk);
    chk("ack_pulse",  32'(ack),   32'd0);
    chk("err_idle",   32'(err),   32'd0);
    chk("busy_idle",  32'(busy),  32'd0);
    chk("sel_idle",   32'(s_sel), 32'd0);
    chk("rdata_hold", rdata,      exp_rd);
  endtask

  initial begin
    logic [31:0] ra;
    int          kind;

    cpu_rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    s_rdy   = '0;   s_rdata = '0;
    repeat (2) @(negedge cpu_clk);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_ack",   32'(ack),     32'd0);
    chk("rst_err",   32'(err),     32'd0);
    chk("rst_rdata", rdata,        32'd0);
    chk("rst_sel",   32'(s_sel),   32'd0);
    chk("rst_saddr", s_addr,       32'd0);
    chk("rst_swe",   32'(s_we),    32'd0);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);

    // Read slave 0 with immediate ready
    randomize_rdata();
    s_rdata[31:0] = 32'h1234_5678;
    run_txn(1'b0, 32'h0000_0010, 32'd0, 4'h0, 0, 1'b0);
    // Write to slave 2, ready three cycles after select
    run_txn(1'b1, 32'hFFFF_F064, 32'h0000_00A5, 4'b0001, 3, 1'b0);
    // Unmapped read
    run_txn(1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, 1'b0);
    // Slave 1 never ready -> timeout
    run_txn(1'b0, 32'hFFFF_F000, 32'd0, 4'h0, 255, 1'b0);
    // Ready on the timeout cycle completes normally; one later times out
    randomize_rdata();
    run_txn(1'b0, 32'hFFFF_F07C, 32'd0, 4'h0, TMO - 1, 1'b0);
    run_txn(1'b0, 32'hFFFF_F07C, 32'd0, 4'h0, TMO, 1'b0);
    // Request during WAIT ignored, then back-to-back request after ack
    randomize_rdata();
    run_txn(1'b0, 32'hFFFF_F068, 32'd0, 4'h0, 5, 1'b1);
    run_txn(1'b0, 32'h0000_ABCC, 32'd0, 4'h0, 1, 1'b0);

    // Reset in the second WAIT cycle
    req = 1'b1; we = 1'b0; addr = 32'hFFFF_F004; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    s_rdy = '0;
    @(negedge cpu_clk);
    req = 1'b0;
    repeat (2) @(negedge cpu_clk);
    chk("pre_rst_sel", 32'(s_sel), 32'd2);
    #2 cpu_rst = 1'b0;
    #1;
    chk("mid_rst_sel",   32'(s_sel),   32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    chk("mid_rst_ack",   32'(ack),     32'd0);
    chk("mid_rst_rdata", rdata,        32'd0);
    chk("mid_rst_saddr", s_addr,       32'd0);
    chk("mid_rst_swdat", s_wdata,      32'd0);
    chk("mid_rst_swstb", 32'(s_wstrb), 32'd0);
    @(negedge cpu_clk);
    #2 cpu_rst = 1'b1;
    @(negedge cpu_clk);
    chk("post_rst_ack",  32'(ack),  32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    randomize_rdata();
    run_txn(1'b0, 32'hFFFF_F00C, 32'd0, 4'h0, 2, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0:       ra = {16'h0000, 16'($urandom)};
        1:       ra = 32'hFFFF_F000 | 32'($urandom_range(0, 15));
        2:       ra = 32'hFFFF_F060 | 32'($urandom_range(0, 15));
        3:       ra = 32'hFFFF_F070 | 32'($urandom_range(0, 15));
        default: ra = $urandom;
      endcase
      randomize_rdata();
      run_txn(1'($urandom), ra, $urandom, 4'($urandom),
              int'($urandom_range(0, TMO + 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
